// File: rtl/cordic_pipe_pkg.sv
// Shared widths and index-word layout for the CORDIC pipeline buffers.
// The index word carries a 7-bit iteration index with a 3-bit quadrant above it.
package cordic_pipe_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int IW_DEFAULT = 10;
  localparam int IDX_W      = 7;
  localparam int QUAD_W     = 3;

  typedef struct packed {
    logic [QUAD_W-1:0] quad;
    logic [IDX_W-1:0]  index;
  } cordic_idx_t;

  function automatic cordic_idx_t split_idx(input logic [IDX_W+QUAD_W-1:0] w);
    return cordic_idx_t'(w);
  endfunction

endpackage

// File: rtl/cordic_delay_line.sv
// Enable-gated shift register of DEPTH stages; q is the last stage.
// flush clears every stage regardless of en (tie low for data chains).
module cordic_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] src;
      logic [WIDTH-1:0] stage_d;
      logic [WIDTH-1:0] stage_q;

      if (gi == 0) begin : g_head
        assign src = d;
      end else begin : g_tail
        assign src = g_stage[gi-1].stage_q;
      end

      always_comb begin
        stage_d = stage_q;
        if (flush) begin
          stage_d = '0;
        end else if (en) begin
          stage_d = src;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end
    end
  endgenerate

  assign q = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/cordic_stage_buffer.sv
// Stall-transparent skew buffer: XM/YM delayed M_LAT en-edges, XR/YR/index/valid
// delayed R_LAT en-edges, with a flushable valid chain and a running occupancy.
module cordic_stage_buffer
  import cordic_pipe_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int IW    = IW_DEFAULT,
  parameter int M_LAT = 1,
  parameter int R_LAT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DW-1:0]              xm_in,
  input  logic [DW-1:0]              ym_in,
  input  logic [DW-1:0]              xr_in,
  input  logic [DW-1:0]              yr_in,
  input  logic [IW-1:0]              idx_in,
  output logic [DW-1:0]              xm_out,
  output logic [DW-1:0]              ym_out,
  output logic [DW-1:0]              xr_out,
  output logic [DW-1:0]              yr_out,
  output logic [IW-1:0]              idx_out,
  output logic                       out_valid,
  output logic [$clog2(R_LAT+1)-1:0] occupancy,
  output logic                       busy
);

  localparam int OCC_W = $clog2(R_LAT + 1);

  generate
    if (R_LAT < 1 || R_LAT > 16 || M_LAT < 1 || M_LAT > R_LAT) begin : g_bad_param
      $error("cordic_stage_buffer: need 1 <= M_LAT <= R_LAT <= 16");
    end
  endgenerate

  cordic_delay_line #(.WIDTH(2*DW), .DEPTH(M_LAT)) u_m_chain (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .flush (1'b0),
    .d     ({xm_in, ym_in}),
    .q     ({xm_out, ym_out})
  );

  cordic_delay_line #(.WIDTH(2*DW+IW), .DEPTH(R_LAT)) u_r_chain (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .flush (1'b0),
    .d     ({xr_in, yr_in, idx_in}),
    .q     ({xr_out, yr_out, idx_out})
  );

  cordic_delay_line #(.WIDTH(1), .DEPTH(R_LAT)) u_v_chain (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .flush (flush),
    .d     (in_valid),
    .q     (out_valid)
  );

  // Occupancy tracks popcount of the valid chain: one enters, the last one leaves.
  logic [OCC_W-1:0] occ_d, occ_q;
  logic             busy_d, busy_q;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      if (in_valid && !out_valid) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (!in_valid && out_valid) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
    busy_d = (occ_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      busy_q <= busy_d;
    end
  end

  assign occupancy = occ_q;
  assign busy      = busy_q;

endmodule
